// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_MUL = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MULT  = 2'd2,
    DONE  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations (codes 0-6); every other code falls back to add.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]        ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic slt;
  assign slt = $signed(a) < $signed(b);

  always_comb begin
    result = a + b;
    case (ctrl)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt};
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: 1-cycle logic/arith ops, iterative 1-bit/cycle shifter, valid/ready handshake.
// Define ALU_MULT_EN to add an iterative shift-add unsigned multiply on code 10.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iValid,
  output logic               oReady,
  input  logic [3:0]         iALUctrl,
  input  logic [DATA_W-1:0]  iA,
  input  logic [DATA_W-1:0]  iB,
  input  logic [SHAMT_W-1:0] iShamt,
  output logic               oValid,
  input  logic               iReady,
  output logic [DATA_W-1:0]  oResult,
  output logic               oZero,
  output logic               oBusy
);

  alu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   comb_res;
  logic                is_shift;
`ifdef ALU_MULT_EN
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
`endif

  alu_comb #(
    .DATA_W (DATA_W)
  ) u_alu_comb (
    .ctrl   (iALUctrl),
    .a      (iA),
    .b      (iB),
    .result (comb_res)
  );

  assign is_shift = (iALUctrl == ALU_SLL) || (iALUctrl == ALU_SRL) || (iALUctrl == ALU_SRA);

  function automatic logic [DATA_W-1:0] shift1(input logic [3:0] op, input logic [DATA_W-1:0] v);
    case (op)
      ALU_SLL: return {v[DATA_W-2:0], 1'b0};
      ALU_SRA: return {v[DATA_W-1], v[DATA_W-1:1]};
      default: return {1'b0, v[DATA_W-1:1]};
    endcase
  endfunction

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          if (is_shift && (iShamt > SHAMT_W'(1))) state_d = SHIFT;
`ifdef ALU_MULT_EN
          else if (iALUctrl == ALU_MUL)          state_d = MULT;
`endif
          else                                    state_d = DONE;
        end
      end
      SHIFT, MULT: if (cnt_q == SHAMT_W'(1)) state_d = DONE;
      DONE:        if (iReady) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // The accept edge already performs the first shift/multiply step, so an N-step
  // operation spends N-1 edges in SHIFT/MULT and oValid rises N cycles after accept.
  always_comb begin
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    zero_d   = zero_q;
`ifdef ALU_MULT_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          op_d  = iALUctrl;
          cnt_d = '0;
          if (is_shift) begin
            if (iShamt == '0) begin
              result_d = iB;
            end else begin
              result_d = shift1(iALUctrl, iB);
              cnt_d    = iShamt - SHAMT_W'(1);
            end
          end
`ifdef ALU_MULT_EN
          else if (iALUctrl == ALU_MUL) begin
            result_d = iB[0] ? iA : '0;
            mcand_d  = iA << 1;
            mplier_d = iB >> 1;
            cnt_d    = SHAMT_W'(DATA_W - 1);
          end
`endif
          else begin
            result_d = comb_res;
          end
          zero_d = (result_d == '0);
        end
      end
      SHIFT: begin
        result_d = shift1(op_q, result_q);
        cnt_d    = cnt_q - SHAMT_W'(1);
        zero_d   = (result_d == '0);
      end
`ifdef ALU_MULT_EN
      MULT: begin
        result_d = mplier_q[0] ? result_q + mcand_q : result_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - SHAMT_W'(1);
        zero_d   = (result_d == '0);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= ALU_ADD;
      zero_q   <= 1'b0;
`ifdef ALU_MULT_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      zero_q   <= zero_d;
`ifdef ALU_MULT_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  always_comb begin
    oReady  = (state_q == IDLE);
    oValid  = (state_q == DONE);
    oBusy   = (state_q != IDLE);
    oResult = result_q;
    oZero   = zero_q;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed, randomized, backpressure and reset cases.
module tb_alu_exec_unit;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [3:0]  iALUctrl = 4'd0;
  logic [31:0] iA = 32'd0;
  logic [31:0] iB = 32'd0;
  logic [4:0]  iShamt = 5'd0;
  logic        oValid;
  logic        iReady = 1'b0;
  logic [31:0] oResult;
  logic        oZero;
  logic        oBusy;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(
    .DATA_W  (32),
    .SHAMT_W (5)
  ) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iValid   (iValid),
    .oReady   (oReady),
    .iALUctrl (iALUctrl),
    .iA       (iA),
    .iB       (iB),
    .iShamt   (iShamt),
    .oValid   (oValid),
    .iReady   (iReady),
    .oResult  (oResult),
    .oZero    (oZero),
    .oBusy    (oBusy)
  );

  always #5 iClk = ~iClk;

  // Reference model: what each op code means arithmetically.
  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a,
                                             input logic [31:0] b, input int sh);
    logic signed [31:0] sb;
    sb = b;
    case (op)
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return ~(a | b);
      7:  return b << sh;
      8:  return b >> sh;
      9:  return sb >>> sh;
`ifdef ALU_MULT_EN
      10: return a * b;
`endif
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input int op, input int sh);
    if (op >= 7 && op <= 9) return (sh == 0) ? 1 : sh;
`ifdef ALU_MULT_EN
    if (op == 10) return 32;
`endif
    return 1;
  endfunction

  // Issue one request, then count edges (accept included) until oValid is seen.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input int sh,
                        input bit rdy, output int lat, output logic [31:0] res,
                        output logic zero);
    @(negedge iClk);
    iValid = 1'b1; iALUctrl = 4'(op); iA = a; iB = b; iShamt = 5'(sh); iReady = rdy;
    @(posedge iClk); #1;
    iValid = 1'b0; iA = $urandom; iB = $urandom; iShamt = 5'($urandom); iALUctrl = 4'($urandom);
    lat = 1;
    while (!oValid && lat < 100) begin
      @(posedge iClk); #1;
      lat++;
    end
    res  = oResult;
    zero = oZero;
  endtask

  task automatic test_reset;
    #1;
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", oValid); end
    total++; if (oResult !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", oResult); end
    total++; if (oZero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", oZero); end
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", oBusy); end
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    @(posedge iClk); #1;
    total++; if (oReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", oReady); end
  endtask

  task automatic test_directed;
    int          ops[$]  = '{0, 1, 1, 4, 9, 8, 7, 11, 12, 13, 14, 15, 10};
    logic [31:0] as[$]   = '{32'h7FFFFFFF, 32'd5, 32'd9, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0,
                             32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'h00010000};
    logic [31:0] bs[$]   = '{32'd1, 32'd5, 32'd4, 32'd1, 32'h80000000, 32'h80000000, 32'h1234,
                             32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'h00010001};
    int          shs[$]  = '{0, 0, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0};
    int          lat;
    logic [31:0] res, exp;
    logic        zero;
    for (int i = 0; i < ops.size(); i++) begin
      exp = ref_result(ops[i], as[i], bs[i], shs[i]);
      run_op(ops[i], as[i], bs[i], shs[i], 1'b1, lat, res, zero);
      total++;
      if (res !== exp) begin bad++; $display("FAIL dir_result op=%0d got=%h want=%h", ops[i], res, exp); end
      total++;
      if (zero !== (exp == 32'd0)) begin bad++; $display("FAIL dir_zero op=%0d got=%b want=%b", ops[i], zero, exp == 32'd0); end
      total++;
      if (lat !== ref_latency(ops[i], shs[i])) begin
        bad++; $display("FAIL dir_latency op=%0d got=%0d want=%0d", ops[i], lat, ref_latency(ops[i], shs[i]));
      end
      @(posedge iClk); #1;
      total++;
      if (oValid !== 1'b0) begin bad++; $display("FAIL dir_valid_drop op=%0d got=%b want=0", ops[i], oValid); end
    end
  endtask

  task automatic test_random;
    int          op, sh, lat;
    logic [31:0] a, b, res, exp;
    logic        zero;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 15);
      sh = $urandom_range(0, 31);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      exp = ref_result(op, a, b, sh);
      run_op(op, a, b, sh, 1'b1, lat, res, zero);
      total++;
      if (res !== exp) begin bad++; $display("FAIL rnd_result op=%0d a=%h b=%h sh=%0d got=%h want=%h", op, a, b, sh, res, exp); end
      total++;
      if (zero !== (exp == 32'd0)) begin bad++; $display("FAIL rnd_zero op=%0d got=%b want=%b", op, zero, exp == 32'd0); end
      total++;
      if (lat !== ref_latency(op, sh)) begin bad++; $display("FAIL rnd_latency op=%0d sh=%0d got=%0d want=%0d", op, sh, lat, ref_latency(op, sh)); end
      @(posedge iClk); #1;
    end
  endtask

  task automatic test_backpressure;
    int          lat;
    logic [31:0] res;
    logic        zero;
    run_op(5, 32'hF0F0, 32'hFFFF, 0, 1'b0, lat, res, zero);
    total++; if (res !== 32'h0F0F) begin bad++; $display("FAIL bp_result got=%h want=0f0f", res); end
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      iValid = 1'b1; iALUctrl = 4'd0; iA = $urandom; iB = $urandom;
      @(posedge iClk); #1;
      total++; if (oValid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, oValid); end
      total++; if (oResult !== 32'h0F0F) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=0f0f", i, oResult); end
      total++; if (oReady !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0", i, oReady); end
    end
    @(negedge iClk);
    iValid = 1'b0; iReady = 1'b1;
    @(posedge iClk); #1;
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", oValid); end
    total++; if (oReady !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b want=1", oReady); end
    @(posedge iClk); #1;
    total++; if (oBusy !== 1'b0 || oValid !== 1'b0) begin bad++; $display("FAIL bp_not_queued busy=%b valid=%b want=0", oBusy, oValid); end
  endtask

  task automatic test_reset_mid_shift;
    int          lat;
    logic [31:0] res;
    logic        zero;
    @(negedge iClk);
    iValid = 1'b1; iALUctrl = 4'd7; iA = 32'd0; iB = 32'h1; iShamt = 5'd20; iReady = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    repeat (6) @(posedge iClk);
    #2;
    total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", oBusy); end
    iRst_n = 1'b0;
    #1;
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", oValid); end
    total++; if (oResult !== 32'd0) begin bad++; $display("FAIL mid_rst_result got=%h want=0", oResult); end
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", oBusy); end
    @(negedge iClk);
    iRst_n = 1'b1;
    run_op(0, 32'd2, 32'd3, 0, 1'b1, lat, res, zero);
    total++; if (res !== 32'd5) begin bad++; $display("FAIL mid_after_result got=%h want=5", res); end
    total++; if (lat !== 1) begin bad++; $display("FAIL mid_after_latency got=%0d want=1", lat); end
    @(posedge iClk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, plus two operands and a shift amount.
- Returns the result and a zero flag over a valid/ready handshake.
- Logic/arithmetic ops complete in 1 cycle. Shifts run on an iterative 1-bit-per-cycle shifter, giving a small-area datapath for the multi-cycle core.

Parameters:
- DATA_W, 32, operand/result width
- SHAMT_W, 5, shift-amount width (log2 DATA_W)

Ports:
- iClk  input  1  clock, rising edge
- iRst_n  input  1  asynchronous active-low reset
- iValid  input  1  request valid
- oReady  output  1  unit can accept request (IDLE only)
- iALUctrl  input  4  op code: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 xor, 6 nor, 7 sll, 8 srl, 9 sra
- iA  input  DATA_W  operand A (rs)
- iB  input  DATA_W  operand B (rt / immediate); shift source
- iShamt  input  SHAMT_W  shift amount
- oValid  output  1  result valid
- iReady  input  1  consumer accepts result
- oResult  output  DATA_W  registered result
- oZero  output  1  registered (oResult == 0)
- oBusy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, iRst_n=0): state IDLE; oValid=0, oResult=0, oZero=0, shift counter=0, oBusy=0. oReady=1 once reset is released. Asserting reset mid-shift aborts the operation with no partial result visible.
- States: IDLE, SHIFT, DONE (plus MULT with the optional feature).
- Accept: on a rising edge with iValid && oReady. Operands are captured at that edge; input changes afterwards are ignored. oReady is 0 outside IDLE.
- Single-cycle ops (codes 0-6, and 10-15): result is computed and registered at the accept edge, then state goes to DONE. oValid is high the next cycle (latency 1).
  - add/sub: modulo 2^DATA_W, no overflow trap.
  - slt: signed compare; result is 1 or 0, zero-extended.
  - nor: ~(A|B).
  - Codes 10-15 are treated as add, matching the decoder default.
- Shifts (7 sll, 8 srl, 9 sra):
  - At accept: result reg = iB, counter = iShamt.
  - If iShamt==0, go directly to DONE (oResult = iB, latency 1). Otherwise go to SHIFT.
  - In SHIFT, each edge shifts the result reg by 1 and decrements the counter. The edge at which counter==1 transitions to DONE.
  - Total latency = max(1, iShamt) cycles from accept to oValid. Shift by 31 = 31 cycles.
  - sra replicates the MSB; srl fills with 0.
- DONE: oValid=1. oResult and oZero are held stable until iReady. iReady in DONE means transfer; the next state is IDLE, with oValid=0 the following cycle. Throughput is therefore at most one op per 2 cycles.
- iReady outside DONE is ignored. iValid outside IDLE is ignored and not queued.
- oZero is updated in the same cycle as oResult, and is valid whenever oValid=1.

Optional Feature:
- Macro ALU_MULT_EN.
- Defined: code 10 = unsigned multiply, low DATA_W bits.
  - Iterative shift-add in MULT state, one multiplier bit per cycle.
  - Latency exactly DATA_W cycles (32).
  - oZero applies to the low word.
- Undefined: no MULT state or multiplier datapath; code 10 behaves as add.

Decomposition:
- Package alu_pkg:
  - op-code localparams ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4, ALU_XOR=5, ALU_NOR=6, ALU_SLL=7, ALU_SRL=8, ALU_SRA=9, ALU_MUL=10
  - state encodings IDLE/SHIFT/MULT/DONE
  - The ALU control decoder is updated to use these constants.
- Sub-module alu_comb: pure combinational block for codes 0-6 and default. The FSM, shifter and optional multiplier stay in alu_exec_unit.

Test Plan:
- add A=0x7FFFFFFF, B=1, iReady=1 → oValid 1 cycle after accept; oResult=0x80000000, oZero=0.
- sub A=5, B=5 → oResult=0, oZero=1. slt A=0xFFFFFFFF (-1), B=1 → oResult=1.
- sra B=0x80000000, shamt=4 → oValid exactly 4 cycles after accept, oResult=0xF8000000. srl with the same inputs → 0x08000000. sll shamt=0, B=0x1234 → latency 1, oResult=0x1234.
- Backpressure: xor A=0xF0F0, B=0xFFFF with iReady=0 for 5 cycles → oValid and oResult=0x0F0F held stable, oReady=0. A new iValid during the stall is not accepted.
- Reset mid-shift: sll shamt=20, pull iRst_n low at cycle 7 → oValid=0, oResult=0 immediately (async). After release, a new add request completes normally.
- Codes 11-15 with A=2, B=3 → oResult=5. With ALU_MULT_EN: code 10, A=0x10000, B=0x10001 → oResult=0x00010000 after 32 cycles. Without the macro, code 10 → 0x20001.
